// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding select
// encoding, sequencer FSM states and the in-flight write scoreboard entry.
package pipe_hazard_ctrl_pkg;

    // Operand source selects for the EXE-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXE = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MC_WAIT = 2'd2
    } state_t;

    // One in-flight register write.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: 5'd0, is_load: 1'b0};

    // True when the entry holds a pending write to register rs.
    // Entries are only ever valid for rd != 0, so x0 can never match.
    function automatic logic sb_match(input sb_entry_t e, input logic [4:0] rs);
        return e.valid && (e.rd == rs);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Connection bundle between the pipeline datapath (master) and the
// hazard controller (slave): ID-stage decode info, EXE events, and the
// stall/flush/issue/forwarding controls going back.
interface pipe_hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic       id_rs1_used;
    logic [4:0] id_rs2;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_rd_wen;
    logic       id_is_load;
    logic       id_is_mc;
    logic       exe_jmp;
    logic       mc_done;

    logic       if_stall;
    logic       id_stall;
    logic       if_id_flush;
    logic       exe_issue;
    logic       exe_hold;
    logic [1:0] fwd_rs1;
    logic [1:0] fwd_rs2;
    logic       mc_err;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rd_wen, id_is_load, id_is_mc, exe_jmp, mc_done,
        input  if_stall, id_stall, if_id_flush, exe_issue, exe_hold,
               fwd_rs1, fwd_rs2, mc_err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rd_wen, id_is_load, id_is_mc, exe_jmp, mc_done,
        output if_stall, id_stall, if_id_flush, exe_issue, exe_hold,
               fwd_rs1, fwd_rs2, mc_err
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// Three-entry shadow of the register writes in flight in EXE, MEM and WB.
// Produces operand-forwarding selects for the instruction in ID and flags
// a load-use hazard against a load sitting in EXE.
module pipe_scoreboard
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,       // EXE keeps its instruction this cycle
    input  logic       drop,       // discard the held EXE entry (aborted op)
    input  logic       ins_valid,  // an rd-writing instruction enters EXE
    input  logic [4:0] ins_rd,
    input  logic       ins_load,
    input  logic [4:0] rs1,
    input  logic       rs1_used,
    input  logic [4:0] rs2,
    input  logic       rs2_used,
    output fwd_sel_t   fwd_rs1,
    output fwd_sel_t   fwd_rs2,
    output logic       load_use
);

    sb_entry_t exe_q, mem_q, wb_q;
    sb_entry_t exe_new;

    // Build the entry for the instruction entering EXE; writes to x0 are never tracked.
    always_comb begin
        // NOTE: give every combinational output a default first so no path leaves it unassigned (that would infer a latch).
        exe_new = SB_EMPTY;
        if (ins_valid && (ins_rd != 5'd0)) begin
            exe_new.valid   = 1'b1;
            exe_new.rd      = ins_rd;
            exe_new.is_load = ins_load;
        end
    end

    // Shift EXE -> MEM -> WB; while EXE holds, MEM gets a bubble and WB still drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q <= SB_EMPTY;
            mem_q <= SB_EMPTY;
            wb_q  <= SB_EMPTY;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before it.
            wb_q <= mem_q;
            if (hold) begin
                mem_q <= SB_EMPTY;
                if (drop) begin
                    exe_q <= SB_EMPTY;
                end
            end else begin
                mem_q <= exe_q;
                exe_q <= exe_new;
            end
        end
    end

    // Youngest producer wins; a load still in EXE has no data yet, so it is not a forward source.
    function automatic fwd_sel_t pick(input logic used, input logic [4:0] rs,
                                      input sb_entry_t e, input sb_entry_t m,
                                      input sb_entry_t w);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (used && (rs != 5'd0)) begin
            if (sb_match(e, rs)) begin
                sel = e.is_load ? FWD_RF : FWD_EXE;
            end else if (sb_match(m, rs)) begin
                sel = FWD_MEM;
            end else if (sb_match(w, rs)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    // Forward selects and load-use detection straight from the current entries.
    always_comb begin
        fwd_rs1  = pick(rs1_used, rs1, exe_q, mem_q, wb_q);
        fwd_rs2  = pick(rs2_used, rs2, exe_q, mem_q, wb_q);
        load_use = exe_q.is_load &&
                   ((rs1_used && sb_match(exe_q, rs1)) ||
                    (rs2_used && sb_match(exe_q, rs2)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: load-use interlock, taken
// jump flush, multi-cycle EXE wait with timeout, and EXE forwarding selects.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYC  = 2,   // bubbles into IF/ID after a taken jump (1..3)
    parameter int MC_TIMEOUT = 64   // cycles to wait for mc_done (>= 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int            TW           = $clog2(MC_TIMEOUT);
    localparam logic [1:0]    FLUSH_RELOAD = 2'(FLUSH_CYC - 1);
    localparam logic [TW-1:0] TCNT_LAST    = TW'(MC_TIMEOUT - 1);
    localparam bit            FLUSH_MULTI  = (FLUSH_CYC > 1);

    state_t        state_q, state_d;
    logic [1:0]    flush_cnt_q;   // flush cycles still to come after the current one
    logic [TW-1:0] tcnt_q;        // cycles spent in MC_WAIT so far
    logic          mc_err_q;

    logic     load_use_raw, load_use, mc_issue, mc_timeout;
    logic     if_stall, id_stall, if_id_flush, exe_issue, exe_hold;
    fwd_sel_t fwd1, fwd2;

    assign load_use   = bus.id_valid && load_use_raw;
    assign mc_issue   = bus.id_valid && bus.id_is_mc && !load_use && !bus.exe_jmp;
    assign mc_timeout = (state_q == ST_MC_WAIT) && !bus.mc_done && (tcnt_q == TCNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: jump beats everything except an in-progress multi-cycle op.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (bus.exe_jmp) begin
                    state_d = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
                end else if (mc_issue) begin
                    state_d = ST_MC_WAIT;
                end
            end
            ST_FLUSH: begin
                if (bus.exe_jmp) begin
                    state_d = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
                end else if (flush_cnt_q == 2'd1) begin
                    state_d = ST_RUN;
                end
            end
            ST_MC_WAIT: begin
                if (bus.mc_done || mc_timeout) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output decode from state plus the current ID/EXE inputs.
    always_comb begin
        if_stall    = 1'b0;
        id_stall    = 1'b0;
        if_id_flush = 1'b0;
        exe_issue   = 1'b0;
        exe_hold    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (bus.exe_jmp) begin
                    if_id_flush = 1'b1;
                end else if (load_use) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                end else begin
                    exe_issue = bus.id_valid;
                end
            end
            ST_FLUSH: begin
                if_id_flush = 1'b1;
            end
            ST_MC_WAIT: begin
                if_stall = 1'b1;
                id_stall = 1'b1;
                exe_hold = 1'b1;
            end
            default: ;
        endcase
    end

    // Flush and timeout counters plus the sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= 2'd0;
            tcnt_q      <= '0;
            mc_err_q    <= 1'b0;
        end else begin
            if (bus.exe_jmp && (state_q != ST_MC_WAIT)) begin
                flush_cnt_q <= FLUSH_RELOAD;
            end else if (state_q == ST_FLUSH) begin
                flush_cnt_q <= flush_cnt_q - 2'd1;
            end

            if (state_q == ST_MC_WAIT) begin
                tcnt_q <= tcnt_q + 1'b1;
            end else begin
                tcnt_q <= '0;
            end

            if (mc_timeout) begin
                mc_err_q <= 1'b1;
            end
        end
    end

    pipe_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (exe_hold),
        .drop      (mc_timeout),
        .ins_valid (exe_issue && bus.id_rd_wen),
        .ins_rd    (bus.id_rd),
        .ins_load  (bus.id_is_load),
        .rs1       (bus.id_rs1),
        .rs1_used  (bus.id_rs1_used),
        .rs2       (bus.id_rs2),
        .rs2_used  (bus.id_rs2_used),
        .fwd_rs1   (fwd1),
        .fwd_rs2   (fwd2),
        .load_use  (load_use_raw)
    );

    assign bus.if_stall    = if_stall;
    assign bus.id_stall    = id_stall;
    assign bus.if_id_flush = if_id_flush;
    assign bus.exe_issue   = exe_issue;
    assign bus.exe_hold    = exe_hold;
    assign bus.fwd_rs1     = fwd1;
    assign bus.fwd_rs2     = fwd2;
    assign bus.mc_err      = mc_err_q;

endmodule
